// File: rtl/rpn_eval.sv
// rpn_eval: 32-bit RPN stack evaluator with single-cycle ALU ops,
// a 32-cycle restoring divider for DIV/MOD and a held EMIT output.
module rpn_eval #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4:0]                 in_op,
    input  logic [31:0]                in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_data,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic [2:0]                 err
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [4:0] OP_PUSH = 5'd0, OP_NEG = 5'd1, OP_NOT = 5'd2, OP_LNOT = 5'd3, OP_RAND = 5'd4;
    localparam logic [4:0] OP_RNAND = 5'd5, OP_ROR = 5'd6, OP_RNOR = 5'd7, OP_RXOR = 5'd8, OP_RXNOR = 5'd9;
    localparam logic [4:0] OP_ADD = 5'd10, OP_SUB = 5'd11, OP_MUL = 5'd12, OP_DIV = 5'd13, OP_MOD = 5'd14;
    localparam logic [4:0] OP_EQ = 5'd15, OP_NE = 5'd16, OP_LT = 5'd17, OP_LE = 5'd18, OP_GT = 5'd19, OP_GE = 5'd20;
    localparam logic [4:0] OP_SHL = 5'd21, OP_SHR = 5'd22, OP_ASHR = 5'd23, OP_AND = 5'd24, OP_OR = 5'd25;
    localparam logic [4:0] OP_XOR = 5'd26, OP_XNOR = 5'd27, OP_LAND = 5'd28, OP_LOR = 5'd29, OP_TERN = 5'd30;
    localparam logic [4:0] OP_EMIT = 5'd31;

    typedef enum logic [1:0] {IDLE, BUSY, EMIT} state_t;

    state_t          r_state, w_nxt;
    logic            r_live;
    logic [DW-1:0]   r_depth;
    logic [2:0]      r_err;
    logic [31:0]     r_out;
    logic [31:0]     r_stk [DEPTH];
    logic [31:0]     r_dvs, r_quo, r_rem;
    logic [4:0]      r_cnt;
    logic            r_neg_q, r_neg_r, r_mod, r_dz;
    logic            w_acc, w_under, w_over, w_div, w_emit, w_big, w_last, w_we, w_ge;
    logic [DW-1:0]   w_need;
    logic [AW-1:0]   w_wi;
    logic [31:0]     w_x, w_a, w_c, w_res, w_wd, w_rem_n, w_quo_n, w_q, w_r, w_dres;
    logic [32:0]     w_sh;

    assign in_ready  = r_live && r_state == IDLE;
    assign out_valid = r_state == EMIT;
    assign out_data  = r_out;
    assign depth     = r_depth;
    assign err       = r_err;

    assign w_x   = r_stk[AW'(r_depth - DW'(1))];
    assign w_a   = r_stk[AW'(r_depth - DW'(2))];
    assign w_c   = r_stk[AW'(r_depth - DW'(3))];
    assign w_big = |w_x[31:5];

    assign w_acc   = in_valid && in_ready;
    assign w_need  = in_op == OP_PUSH ? DW'(0) : in_op <= OP_RXNOR ? DW'(1) :
                     in_op <= OP_LOR ? DW'(2) : in_op == OP_TERN ? DW'(3) : DW'(1);
    assign w_under = w_need > r_depth;
    assign w_over  = in_op == OP_PUSH && r_depth == DW'(DEPTH);
    assign w_div   = in_op == OP_DIV || in_op == OP_MOD;
    assign w_emit  = in_op == OP_EMIT;

    // One restoring step on magnitudes; signs are applied after the last step.
    assign w_sh    = {r_rem, r_quo[31]};
    assign w_ge    = w_sh >= {1'b0, r_dvs};
    assign w_rem_n = w_ge ? 32'(w_sh - {1'b0, r_dvs}) : w_sh[31:0];
    assign w_quo_n = {r_quo[30:0], w_ge};
    assign w_q     = r_neg_q ? -w_quo_n : w_quo_n;
    assign w_r     = r_neg_r ? -w_rem_n : w_rem_n;
    assign w_dres  = r_dz ? '0 : r_mod ? w_r : w_q;
    assign w_last  = r_state == BUSY && r_cnt == 5'd31;

    assign w_we = (w_acc && !w_under && !w_over && !w_div && !w_emit) || w_last;
    assign w_wi = w_last ? AW'(r_depth - DW'(2)) : AW'(r_depth - w_need);
    assign w_wd = w_last ? w_dres : w_res;

    always_comb begin
        w_res = '0;
        case (in_op)
            OP_PUSH:  w_res = in_data;
            OP_NEG:   w_res = -w_x;
            OP_NOT:   w_res = ~w_x;
            OP_LNOT:  w_res = 32'(w_x == '0);
            OP_RAND:  w_res = 32'(&w_x);
            OP_RNAND: w_res = 32'(~&w_x);
            OP_ROR:   w_res = 32'(|w_x);
            OP_RNOR:  w_res = 32'(~|w_x);
            OP_RXOR:  w_res = 32'(^w_x);
            OP_RXNOR: w_res = 32'(~^w_x);
            OP_ADD:   w_res = w_a + w_x;
            OP_SUB:   w_res = w_a - w_x;
            OP_MUL:   w_res = w_a * w_x;
            OP_EQ:    w_res = 32'(w_a == w_x);
            OP_NE:    w_res = 32'(w_a != w_x);
            OP_LT:    w_res = 32'($signed(w_a) < $signed(w_x));
            OP_LE:    w_res = 32'($signed(w_a) <= $signed(w_x));
            OP_GT:    w_res = 32'($signed(w_a) > $signed(w_x));
            OP_GE:    w_res = 32'($signed(w_a) >= $signed(w_x));
            OP_SHL:   w_res = w_big ? '0 : w_a << w_x[4:0];
            OP_SHR:   w_res = w_big ? '0 : w_a >> w_x[4:0];
            OP_ASHR:  w_res = w_big ? {32{w_a[31]}} : 32'($signed(w_a) >>> w_x[4:0]);
            OP_AND:   w_res = w_a & w_x;
            OP_OR:    w_res = w_a | w_x;
            OP_XOR:   w_res = w_a ^ w_x;
            OP_XNOR:  w_res = ~(w_a ^ w_x);
            OP_LAND:  w_res = 32'(w_a != '0 && w_x != '0);
            OP_LOR:   w_res = 32'(w_a != '0 || w_x != '0);
            OP_TERN:  w_res = w_c != '0 ? w_a : w_x;
            default:  w_res = '0;
        endcase
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE:    w_nxt = !w_acc || w_under ? IDLE : w_div ? BUSY : w_emit ? EMIT : IDLE;
            BUSY:    w_nxt = w_last ? IDLE : BUSY;
            EMIT:    w_nxt = out_ready ? IDLE : EMIT;
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_we)
            r_stk[w_wi] <= w_wd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_live  <= 1'b0;
            r_depth <= '0;
            r_err   <= '0;
            r_out   <= '0;
            r_dvs   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_mod   <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_live  <= 1'b1;
            if (w_acc) begin
                if (w_under)
                    r_err[0] <= 1'b1;
                else if (w_over)
                    r_err[1] <= 1'b1;
                else if (w_emit) begin
                    r_out   <= w_x;
                    r_depth <= r_depth - DW'(1);
                end else if (w_div) begin
                    r_quo   <= w_a[31] ? -w_a : w_a;
                    r_dvs   <= w_x[31] ? -w_x : w_x;
                    r_rem   <= '0;
                    r_cnt   <= '0;
                    r_neg_q <= w_a[31] ^ w_x[31];
                    r_neg_r <= w_a[31];
                    r_mod   <= in_op == OP_MOD;
                    r_dz    <= w_x == '0;
                end else
                    r_depth <= r_depth - w_need + DW'(1);
            end
            if (r_state == BUSY) begin
                r_cnt <= r_cnt + 5'd1;
                r_rem <= w_rem_n;
                r_quo <= w_quo_n;
                if (w_last) begin
                    r_depth  <= r_depth - DW'(1);
                    r_err[2] <= r_err[2] | r_dz;
                end
            end
        end
    end
endmodule

// File: tb/tb_rpn_eval.sv
// tb_rpn_eval: directed RPN programs; expected EMIT results are queued by the
// stimulus and compared by an independent output monitor.
module tb_rpn_eval;
    localparam logic [4:0] PUSH = 5'd0, NEG = 5'd1, NOT = 5'd2, LNOT = 5'd3, RXOR = 5'd8;
    localparam logic [4:0] ADD = 5'd10, SUB = 5'd11, MUL = 5'd12, DIV = 5'd13, MOD = 5'd14;
    localparam logic [4:0] LT = 5'd17, GE = 5'd20, SHL = 5'd21, SHR = 5'd22, ASHR = 5'd23;
    localparam logic [4:0] LAND = 5'd28, TERN = 5'd30, EMIT = 5'd31;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_op = '0;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [3:0]  depth;
    logic [2:0]  err;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    rpn_eval dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .depth(depth), .err(err)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out got 0x%0h expected no output", out_data);
            end else
                chk("out_data", out_data, exp_q.pop_front());
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic tok(input logic [4:0] op, input logic [31:0] d);
        @(negedge clk);
        wait_ready();
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic emit(input logic [31:0] e);
        exp_q.push_back(e);
        tok(EMIT, 32'd0);
    endtask

    task automatic run_bin(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op, input logic [31:0] e);
        tok(PUSH, a);
        tok(PUSH, b);
        tok(op, 32'd0);
        emit(e);
    endtask

    task automatic run_un(input logic [31:0] a, input logic [4:0] op, input logic [31:0] e);
        tok(PUSH, a);
        tok(op, 32'd0);
        emit(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        do_reset();
        run_bin(32'd42, 32'd9, ADD, 32'd51);
        chk("add_depth", 32'(depth), 32'd0);
        chk("add_err", 32'(err), 32'd0);
        run_bin(32'd42, 32'd9, SUB, 32'd33);
        run_bin(32'd42, 32'd9, MUL, 32'd378);

        tok(PUSH, 32'd42);
        tok(PUSH, 32'd9);
        tok(DIV, 32'd0);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("div_busy_cycles", 32'(n), 32'd32);
        chk("div_depth", 32'(depth), 32'd1);
        emit(32'd4);
        run_bin(32'd42, 32'd9, MOD, 32'd6);
        run_bin(-32'sd7, 32'd2, DIV, 32'hFFFF_FFFD);
        run_bin(-32'sd7, 32'd2, MOD, 32'hFFFF_FFFF);
        run_bin(32'd7, 32'hFFFF_FFFE, MOD, 32'd1);
        run_bin(32'h8000_0000, 32'hFFFF_FFFF, DIV, 32'h8000_0000);

        run_un(32'd42, NEG, 32'd4294967254);
        run_un(32'd42, RXOR, 32'd1);
        run_un(32'd9, RXOR, 32'd0);
        run_un(32'd0, LNOT, 32'd1);
        run_un(32'd0, NOT, 32'hFFFF_FFFF);
        run_bin(32'hFFFF_FFFF, 32'd9, SHR, 32'd8388607);
        run_bin(32'hFFFF_FFFF, 32'd9, ASHR, 32'hFFFF_FFFF);
        run_bin(32'd42, 32'd9, SHL, 32'd21504);
        run_bin(32'd1, 32'd32, SHL, 32'd0);
        run_bin(32'h8000_0000, 32'd31, SHR, 32'd1);
        run_bin(32'd3, 32'd40, ASHR, 32'd0);
        run_bin(32'h8000_0000, 32'd40, ASHR, 32'hFFFF_FFFF);
        run_bin(32'hFFFF_FFFF, 32'd1, LT, 32'd1);
        run_bin(32'd5, 32'd5, GE, 32'd1);
        run_bin(32'd3, 32'd0, LAND, 32'd0);

        tok(PUSH, 32'd1);
        tok(PUSH, 32'd42);
        tok(PUSH, 32'd9001);
        tok(TERN, 32'd0);
        out_ready = 1'b0;
        tok(EMIT, 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", out_data, 32'd42);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        exp_q.push_back(32'd42);
        @(posedge clk);
        #2 out_ready = 1'b1;
        tok(PUSH, 32'd0);
        tok(PUSH, 32'd42);
        tok(PUSH, 32'd9001);
        tok(TERN, 32'd0);
        emit(32'd9001);
        chk("tern_depth", 32'(depth), 32'd0);

        do_reset();
        tok(ADD, 32'd0);
        chk("underflow_err", 32'(err), 32'b001);
        chk("underflow_depth", 32'(depth), 32'd0);
        tok(EMIT, 32'd0);
        chk("empty_emit_valid", 32'(out_valid), 32'd0);

        do_reset();
        for (int i = 0; i < 9; i++) tok(PUSH, 32'(i));
        chk("overflow_err", 32'(err), 32'b010);
        chk("overflow_depth", 32'(depth), 32'd8);
        emit(32'd7);

        do_reset();
        tok(PUSH, 32'd5);
        tok(PUSH, 32'd0);
        tok(DIV, 32'd0);
        @(negedge clk);
        wait_ready();
        chk("divzero_err", 32'(err), 32'b100);
        chk("divzero_depth", 32'(depth), 32'd1);
        emit(32'd0);

        do_reset();
        tok(PUSH, 32'd42);
        tok(PUSH, 32'd9);
        tok(DIV, 32'd0);
        for (int i = 0; i < 9; i++) @(negedge clk);
        do_reset();
        repeat (40) @(negedge clk);
        chk("abort_depth", 32'(depth), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        tok(PUSH, 32'd7);
        chk("post_abort_depth", 32'(depth), 32'd1);
        emit(32'd7);

        repeat (4) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
